// File: rtl/formula_isqrt_pkg.sv
// Shared types and elaboration-time sizing helpers for the isqrt-sum formula block.
package formula_isqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic int unsigned n_rounds(input int unsigned n_args, input int unsigned n_isqrt);
    return (n_args + n_isqrt - 1) / n_isqrt;
  endfunction

  function automatic int unsigned y_w(input int unsigned arg_w);
    return arg_w / 2;
  endfunction

  // Sum of n_args values of y_w bits each can never overflow this width.
  function automatic int unsigned acc_w(input int unsigned arg_w, input int unsigned n_args);
    return arg_w / 2 + $clog2(n_args);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/isqrt_batch_accum.sv
// Tracks outstanding isqrt lanes of the current batch and accumulates their results.
module isqrt_batch_accum
  import formula_isqrt_pkg::*;
#(
  parameter int unsigned N_ISQRT = 2,
  parameter int unsigned Y_W     = 16,
  parameter int unsigned ACC_W   = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   issue,
  input  logic [N_ISQRT-1:0]     issue_mask,
  input  logic                   wait_en,
  input  logic [N_ISQRT-1:0]     y_vld,
  input  logic [N_ISQRT*Y_W-1:0] y,
  output logic [ACC_W-1:0]       acc_nxt_c,
  output logic                   batch_done_c
);

  logic [N_ISQRT-1:0] pending;
  logic [N_ISQRT-1:0] pending_n;
  logic [N_ISQRT-1:0] ret;
  logic [ACC_W-1:0]   acc;

  // Returns on non-pending lanes are masked off; simultaneous returns add in one cycle.
  always_comb begin
    ret       = '0;
    pending_n = pending;
    acc_nxt_c = acc;
    if (clear) begin
      pending_n = '0;
      acc_nxt_c = '0;
    end else if (issue) begin
      pending_n = issue_mask;
    end else if (wait_en) begin
      ret       = y_vld & pending;
      pending_n = pending & ~ret;
      for (int l = 0; l < int'(N_ISQRT); l++) begin
        if (ret[l]) acc_nxt_c = acc_nxt_c + ACC_W'(y[l*Y_W +: Y_W]);
      end
    end
    batch_done_c = wait_en && (pending_n == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      acc     <= '0;
    end else begin
      pending <= pending_n;
      acc     <= acc_nxt_c;
    end
  end

endmodule

// File: rtl/formula_sum_isqrt_fsm.sv
// Sums isqrt(arg_i) over N_ARGS operands by issuing batches to N_ISQRT external isqrt units.
module formula_sum_isqrt_fsm
  import formula_isqrt_pkg::*;
#(
  parameter int unsigned N_ARGS  = 3,
  parameter int unsigned N_ISQRT = 2,
  parameter int unsigned ARG_W   = 32,
  parameter int unsigned RES_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arg_vld,
  output logic                           arg_rdy,
  input  logic [N_ARGS*ARG_W-1:0]        args,
  output logic                           res_vld,
  output logic [RES_W-1:0]               res,
  output logic [N_ISQRT-1:0]             isqrt_x_vld,
  output logic [N_ISQRT*ARG_W-1:0]       isqrt_x,
  input  logic [N_ISQRT-1:0]             isqrt_y_vld,
  input  logic [N_ISQRT*(ARG_W/2)-1:0]   isqrt_y
);

  localparam int unsigned Y_W   = y_w(ARG_W);
  localparam int unsigned ACC_W = acc_w(ARG_W, N_ARGS);
  localparam int unsigned R     = n_rounds(N_ARGS, N_ISQRT);
  localparam int unsigned B_W   = cnt_w(R);

  if (RES_W < ACC_W || N_ARGS < 1 || N_ISQRT < 1 || (ARG_W % 2) != 0) begin : g_param_check
    $error("formula_sum_isqrt_fsm: illegal parameters (RES_W too small or bad N_ARGS/N_ISQRT/ARG_W)");
  end

  state_t                    state, state_n;
  logic [B_W-1:0]            batch, batch_n;
  logic [N_ARGS*ARG_W-1:0]   args_q, args_n;
  logic [N_ISQRT-1:0]        issue_mask;
  logic [ACC_W-1:0]          acc_nxt_c;
  logic                      batch_done_c;
  logic                      accept_c;
  logic                      issue_c;
  logic                      wait_c;

  logic                      arg_rdy_n;
  logic                      res_vld_n;
  logic [RES_W-1:0]          res_n;
  logic [N_ISQRT-1:0]        x_vld_n;
  logic [N_ISQRT*ARG_W-1:0]  x_n;

  assign accept_c = (state == ST_IDLE) && arg_vld;
  assign issue_c  = (state == ST_ISSUE);
  assign wait_c   = (state == ST_WAIT);

  isqrt_batch_accum #(
    .N_ISQRT (N_ISQRT),
    .Y_W     (Y_W),
    .ACC_W   (ACC_W)
  ) u_accum (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept_c),
    .issue        (issue_c),
    .issue_mask   (issue_mask),
    .wait_en      (wait_c),
    .y_vld        (isqrt_y_vld),
    .y            (isqrt_y),
    .acc_nxt_c    (acc_nxt_c),
    .batch_done_c (batch_done_c)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_n    = state;
    batch_n    = batch;
    args_n     = args_q;
    issue_mask = '0;
    x_vld_n    = '0;
    x_n        = '0;

    case (state)
      ST_IDLE: begin
        if (arg_vld) begin
          args_n  = args;
          batch_n = '0;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (batch_done_c) begin
          if (batch == B_W'(R - 1)) begin
            state_n = ST_DONE;
          end else begin
            batch_n = batch + B_W'(1);
            state_n = ST_ISSUE;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Lane l of round r carries arg r*N_ISQRT+l; indices past N_ARGS stay idle.
    for (int unsigned r = 0; r < R; r++) begin
      for (int unsigned l = 0; l < N_ISQRT; l++) begin
        if (r * N_ISQRT + l < N_ARGS) begin
          if (batch == B_W'(r)) issue_mask[l] = 1'b1;
          if (state_n == ST_ISSUE && batch_n == B_W'(r)) begin
            x_vld_n[l]               = 1'b1;
            x_n[l*ARG_W +: ARG_W]    = args_n[(r*N_ISQRT + l)*ARG_W +: ARG_W];
          end
        end
      end
    end

    arg_rdy_n = (state_n == ST_IDLE);
    res_vld_n = (state_n == ST_DONE);
    res_n     = res_vld_n ? RES_W'(acc_nxt_c) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      batch       <= '0;
      args_q      <= '0;
      arg_rdy     <= 1'b1;
      res_vld     <= 1'b0;
      res         <= '0;
      isqrt_x_vld <= '0;
      isqrt_x     <= '0;
    end else begin
      state       <= state_n;
      batch       <= batch_n;
      args_q      <= args_n;
      arg_rdy     <= arg_rdy_n;
      res_vld     <= res_vld_n;
      res         <= res_n;
      isqrt_x_vld <= x_vld_n;
      isqrt_x     <= x_n;
    end
  end

endmodule

// File: tb/tb_formula_sum_isqrt_fsm.sv
// Bench for formula_sum_isqrt_fsm: isqrt model with per-lane latency, vector table plus corner sequences.
module tb_formula_sum_isqrt_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 3 args, 2 lanes
  logic         arg_vld_a, arg_rdy_a, res_vld_a;
  logic [95:0]  args_a;
  logic [31:0]  res_a;
  logic [1:0]   x_vld_a, y_vld_a;
  logic [63:0]  x_a;
  logic [31:0]  y_a;

  // DUT B: 5 args, 2 lanes
  logic         arg_vld_b, arg_rdy_b, res_vld_b;
  logic [159:0] args_b;
  logic [31:0]  res_b;
  logic [1:0]   x_vld_b, y_vld_b, stray_b;
  logic [63:0]  x_b;
  logic [31:0]  y_b;

  formula_sum_isqrt_fsm #(.N_ARGS(3), .N_ISQRT(2), .ARG_W(32), .RES_W(32)) dut_a (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_a), .arg_rdy(arg_rdy_a), .args(args_a),
    .res_vld(res_vld_a), .res(res_a), .isqrt_x_vld(x_vld_a), .isqrt_x(x_a),
    .isqrt_y_vld(y_vld_a), .isqrt_y(y_a)
  );

  formula_sum_isqrt_fsm #(.N_ARGS(5), .N_ISQRT(2), .ARG_W(32), .RES_W(32)) dut_b (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_b), .arg_rdy(arg_rdy_b), .args(args_b),
    .res_vld(res_vld_b), .res(res_b), .isqrt_x_vld(x_vld_b), .isqrt_x(x_b),
    .isqrt_y_vld(y_vld_b), .isqrt_y(y_b)
  );

  function automatic logic [15:0] isqrt32(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if (32'(t) * 32'(t) <= x) r = t;
    end
    return r;
  endfunction

  // isqrt models: y_vld exactly lat cycles after x_vld; share rst with the DUTs
  int          lat_a [2];
  int          cnt_a [2];
  logic [15:0] val_a [2];
  int          lat_b [2];
  int          cnt_b [2];
  logic [15:0] val_b [2];

  always @(posedge clk or negedge rst) begin
    for (int l = 0; l < 2; l++) begin
      if (!rst) begin
        cnt_a[l] <= 0;
        cnt_b[l] <= 0;
      end else begin
        if (x_vld_a[l]) begin
          cnt_a[l] <= lat_a[l];
          val_a[l] <= isqrt32(x_a[l*32 +: 32]);
        end else if (cnt_a[l] > 0) cnt_a[l] <= cnt_a[l] - 1;
        if (x_vld_b[l]) begin
          cnt_b[l] <= lat_b[l];
          val_b[l] <= isqrt32(x_b[l*32 +: 32]);
        end else if (cnt_b[l] > 0) cnt_b[l] <= cnt_b[l] - 1;
      end
    end
  end

  always_comb begin
    y_vld_a = '0;
    y_a     = '0;
    y_vld_b = '0;
    y_b     = '0;
    for (int l = 0; l < 2; l++) begin
      y_vld_a[l]        = (cnt_a[l] == 1);
      y_a[l*16 +: 16]   = (cnt_a[l] == 1) ? val_a[l] : 16'h0;
      y_vld_b[l]        = (cnt_b[l] == 1) | stray_b[l];
      y_b[l*16 +: 16]   = (cnt_b[l] == 1) ? val_b[l] : (stray_b[l] ? 16'd77 : 16'h0);
    end
  end

  // Output monitors: first result, its cycle offset, pulse and issue counts
  int          ncyc_a, npulse_a, at_a, xc_a0, xc_a1;
  int          ncyc_b, npulse_b, at_b, xc_b0, xc_b1;
  int          zero_err;
  logic [31:0] seen_a, seen_b;

  always @(negedge clk) begin
    if (res_vld_a) begin
      if (npulse_a == 0) begin
        seen_a = res_a;
        at_a   = ncyc_a;
      end
      npulse_a++;
    end else if (res_a != 0) zero_err++;
    if (res_vld_b) begin
      if (npulse_b == 0) begin
        seen_b = res_b;
        at_b   = ncyc_b;
      end
      npulse_b++;
    end else if (res_b != 0) zero_err++;
    if (x_vld_a[0]) xc_a0++;
    if (x_vld_a[1]) xc_a1++;
    if (x_vld_b[0]) xc_b0++;
    if (x_vld_b[1]) xc_b1++;
    ncyc_a++;
    ncyc_b++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [95:0] args;
    int          lat0;
    int          lat1;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vt [5];

  task automatic run_a(input vec_t v, input int idx);
    lat_a[0] = v.lat0;
    lat_a[1] = v.lat1;
    @(negedge clk);
    chk($sformatf("v%0d_rdy_idle", idx), longint'(arg_rdy_a), 1);
    args_a    = v.args;
    arg_vld_a = 1'b1;
    @(posedge clk);
    npulse_a = 0; xc_a0 = 0; xc_a1 = 0; ncyc_a = 0; at_a = -1;
    @(negedge clk);
    arg_vld_a = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk($sformatf("v%0d_res", idx), longint'(seen_a), longint'(v.exp_res));
    chk($sformatf("v%0d_latency", idx), longint'(at_a + 1), longint'(v.exp_lat));
    chk($sformatf("v%0d_pulses", idx), longint'(npulse_a), 1);
    chk($sformatf("v%0d_lane0_issues", idx), longint'(xc_a0), 2);
    chk($sformatf("v%0d_lane1_issues", idx), longint'(xc_a1), 1);
  endtask

  int          rv_n;
  int          rv_k [4];
  logic [31:0] rv_res [4];
  int          busy_rdy;

  initial begin
    vt[0] = '{args: {32'd36, 32'd25, 32'd16},                  lat0: 4, lat1: 4, exp_res: 32'd15,     exp_lat: 11};
    vt[1] = '{args: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, lat0: 1, lat1: 1, exp_res: 32'd196605, exp_lat: 5};
    vt[2] = '{args: {32'd9, 32'd4, 32'd1},                      lat0: 2, lat1: 7, exp_res: 32'd6,      exp_lat: 12};
    vt[3] = '{args: {32'd2, 32'd1, 32'd0},                      lat0: 3, lat1: 3, exp_res: 32'd2,      exp_lat: 9};
    vt[4] = '{args: {32'd3, 32'd99, 32'd100},                   lat0: 2, lat1: 2, exp_res: 32'd20,     exp_lat: 7};

    rst = 1'b0;
    arg_vld_a = 1'b0; args_a = '0;
    arg_vld_b = 1'b0; args_b = '0; stray_b = '0;
    lat_a[0] = 1; lat_a[1] = 1; lat_b[0] = 1; lat_b[1] = 1;
    zero_err = 0;

    #12;
    chk("reset_arg_rdy", longint'(arg_rdy_a), 1);
    chk("reset_res_vld", longint'(res_vld_a), 0);
    chk("reset_res", longint'(res_a), 0);
    chk("reset_x_vld", longint'(x_vld_a), 0);
    chk("reset_arg_rdy_b", longint'(arg_rdy_b), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_a(vt[i], i);

    // Five args over three rounds; stray y_vld on idle lane 1 during round 3
    lat_b[0] = 3;
    lat_b[1] = 3;
    @(negedge clk);
    chk("b_rdy_idle", longint'(arg_rdy_b), 1);
    args_b    = {32'd100, 32'd16, 32'd9, 32'd4, 32'd1};
    arg_vld_b = 1'b1;
    @(posedge clk);
    npulse_b = 0; xc_b0 = 0; xc_b1 = 0; ncyc_b = 0; at_b = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) arg_vld_b = 1'b0;
      if (k == 9) stray_b = 2'b10;
      if (k == 10) stray_b = 2'b00;
    end
    #1;
    chk("b_res", longint'(seen_b), 20);
    chk("b_latency", longint'(at_b + 1), 13);
    chk("b_pulses", longint'(npulse_b), 1);
    chk("b_lane0_issues", longint'(xc_b0), 3);
    chk("b_lane1_issues", longint'(xc_b1), 2);

    // arg_vld held high: second request taken right after the result strobe
    lat_a[0] = 4;
    lat_a[1] = 4;
    rv_n = 0;
    busy_rdy = 0;
    @(negedge clk);
    args_a    = {32'd36, 32'd25, 32'd16};
    arg_vld_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k <= 10 && arg_rdy_a) busy_rdy++;
      if (k == 11) chk("b2b_rdy_after_res", longint'(arg_rdy_a), 1);
      if (res_vld_a && rv_n < 4) begin
        rv_k[rv_n]   = k;
        rv_res[rv_n] = res_a;
        rv_n++;
      end
      if (k == 10) args_a = {32'd9, 32'd4, 32'd1};
      if (k == 12) arg_vld_a = 1'b0;
    end
    chk("b2b_busy_rdy", longint'(busy_rdy), 0);
    chk("b2b_pulses", longint'(rv_n), 2);
    chk("b2b_res0", longint'(rv_res[0]), 15);
    chk("b2b_res1", longint'(rv_res[1]), 6);
    chk("b2b_at0", longint'(rv_k[0]), 10);
    chk("b2b_at1", longint'(rv_k[1]), 22);

    // Reset during ST_WAIT takes effect immediately
    @(negedge clk);
    args_a    = {32'd36, 32'd25, 32'd16};
    arg_vld_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arg_vld_a = 1'b0;
    @(negedge clk);
    chk("mid_busy_rdy", longint'(arg_rdy_a), 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_arg_rdy", longint'(arg_rdy_a), 1);
    chk("mid_rst_res_vld", longint'(res_vld_a), 0);
    chk("mid_rst_x_vld", longint'(x_vld_a), 0);
    @(negedge clk);
    rst = 1'b1;
    run_a('{args: 96'd0, lat0: 4, lat1: 4, exp_res: 32'd0, exp_lat: 11}, 9);

    chk("res_zero_when_idle", longint'(zero_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
